// File: rtl/game_control.sv
// Duck-hunt game sequencer: drives the shared state bus, commands the dog
// animations and keeps the shot, hit, duck-count and fly-away bookkeeping.
module game_control #(
    parameter int DUCKS_PER_GAME = 10,
    parameter int SHOTS_PER_DUCK = 3,
    parameter int FLY_FRAMES     = 300,
    parameter int FLYAWAY_FRAMES = 90
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_btn,
    input  logic       trigger,
    input  logic       hit,
    input  logic       duck_landed,
    input  logic       dog_start,
    input  logic       dog_duck,
    output logic [2:0] state,
    output logic       new_duck,
    output logic [1:0] shots_left,
    output logic [3:0] ducks_hit,
    output logic [3:0] duck_num
);

    typedef enum logic [2:0] {
        S_TITLE     = 3'b000,
        S_MISS      = 3'b001,
        S_DOG_RESET = 3'b010,
        S_FLY       = 3'b011,
        S_FALL      = 3'b100,
        S_DOG_DUCK  = 3'b101,
        S_DOG_INTRO = 3'b110,
        S_GAME_OVER = 3'b111
    } state_t;

    typedef enum logic {
        NEXT_INTRO = 1'b0,
        NEXT_DUCK  = 1'b1
    } dog_next_t;

    localparam logic [3:0] DUCKS_LIM   = 4'(DUCKS_PER_GAME);
    localparam logic [1:0] SHOTS_LIM   = 2'(SHOTS_PER_DUCK);
    localparam logic [8:0] FLY_LIM     = 9'(FLY_FRAMES);
    localparam logic [8:0] FLYAWAY_LIM = 9'(FLYAWAY_FRAMES);

    logic      fc_q,         fc_d;
    logic      fe_q,         fe_d;
    logic      start_q,      start_d;
    logic      start_edge_q, start_edge_d;
    logic      trig_q,       trig_d;
    logic      trig_edge_q,  trig_edge_d;

    state_t    state_q,      state_d;
    dog_next_t dog_next_q,   dog_next_d;
    logic [1:0] shots_q,     shots_d;
    logic [3:0] ducks_hit_q, ducks_hit_d;
    logic [3:0] duck_num_q,  duck_num_d;
    logic [8:0] fly_timer_q, fly_timer_d;
    logic [8:0] miss_timer_q, miss_timer_d;
    logic       new_duck_q,  new_duck_d;

    logic       shot_s;
    logic       duck_done_s;
    logic       enter_fly_s;
    logic [8:0] fly_inc_s;
    logic [8:0] miss_inc_s;

    // Input edge detectors; each edge is itself registered so it is a clean one-cycle pulse.
    always_comb begin
        fc_d         = frame_clk;
        fe_d         = frame_clk & ~fc_q;
        start_d      = start_btn;
        start_edge_d = start_btn & ~start_q;
        trig_d       = trigger;
        trig_edge_d  = trigger & ~trig_q;
    end

    // Edge-detector flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q         <= 1'b0;
            fe_q         <= 1'b0;
            start_q      <= 1'b0;
            start_edge_q <= 1'b0;
            trig_q       <= 1'b0;
            trig_edge_q  <= 1'b0;
        end else begin
            fc_q         <= fc_d;
            fe_q         <= fe_d;
            start_q      <= start_d;
            start_edge_q <= start_edge_d;
            trig_q       <= trig_d;
            trig_edge_q  <= trig_edge_d;
        end
    end

    // Next-state and bookkeeping for the game sequencer.
    always_comb begin
        state_d      = state_q;
        dog_next_d   = dog_next_q;
        shots_d      = shots_q;
        ducks_hit_d  = ducks_hit_q;
        duck_num_d   = duck_num_q;
        fly_timer_d  = fly_timer_q;
        miss_timer_d = miss_timer_q;
        new_duck_d   = 1'b0;
        duck_done_s  = 1'b0;
        enter_fly_s  = 1'b0;
        shot_s       = trig_edge_q && (shots_q != 2'd0);
        fly_inc_s    = fe_q ? (fly_timer_q + 9'd1) : fly_timer_q;
        miss_inc_s   = fe_q ? (miss_timer_q + 9'd1) : miss_timer_q;

        case (state_q)
            S_TITLE: begin
                if (start_edge_q) begin
                    state_d      = S_DOG_RESET;
                    dog_next_d   = NEXT_INTRO;
                    ducks_hit_d  = 4'd0;
                    duck_num_d   = 4'd0;
                    fly_timer_d  = 9'd0;
                    miss_timer_d = 9'd0;
                end else begin
                    state_d = S_TITLE;
                end
            end
            S_DOG_RESET: begin
                if (dog_next_q == NEXT_INTRO) begin
                    state_d = S_DOG_INTRO;
                end else begin
                    state_d = S_DOG_DUCK;
                end
            end
            S_DOG_INTRO: begin
                if (dog_start) begin
                    enter_fly_s = 1'b1;
                end else begin
                    state_d = S_DOG_INTRO;
                end
            end
            S_FLY: begin
                if (shot_s) begin
                    shots_d = shots_q - 2'd1;
                end else begin
                    shots_d = shots_q;
                end
                fly_timer_d = fly_inc_s;
                // A hit always wins, even against the last shell or the timeout.
                if (hit) begin
                    ducks_hit_d = (ducks_hit_q == 4'd15) ? 4'd15 : (ducks_hit_q + 4'd1);
                    state_d     = S_FALL;
                end else if (shot_s && (shots_q == 2'd1)) begin
                    state_d      = S_MISS;
                    miss_timer_d = 9'd0;
                end else if (fly_inc_s == FLY_LIM) begin
                    state_d      = S_MISS;
                    miss_timer_d = 9'd0;
                end else begin
                    state_d = S_FLY;
                end
            end
            S_FALL: begin
                if (duck_landed) begin
                    state_d    = S_DOG_RESET;
                    dog_next_d = NEXT_DUCK;
                end else begin
                    state_d = S_FALL;
                end
            end
            S_DOG_DUCK: begin
                if (dog_duck) begin
                    duck_done_s = 1'b1;
                end else begin
                    state_d = S_DOG_DUCK;
                end
            end
            S_MISS: begin
                miss_timer_d = miss_inc_s;
                if (miss_inc_s == FLYAWAY_LIM) begin
                    duck_done_s = 1'b1;
                end else begin
                    state_d = S_MISS;
                end
            end
            S_GAME_OVER: begin
                if (start_edge_q) begin
                    state_d      = S_DOG_RESET;
                    dog_next_d   = NEXT_INTRO;
                    ducks_hit_d  = 4'd0;
                    duck_num_d   = 4'd0;
                    fly_timer_d  = 9'd0;
                    miss_timer_d = 9'd0;
                end else begin
                    state_d = S_GAME_OVER;
                end
            end
            default: begin
                state_d = S_TITLE;
            end
        endcase

        if (duck_done_s) begin
            duck_num_d = duck_num_q + 4'd1;
            if (duck_num_d == DUCKS_LIM) begin
                state_d = S_GAME_OVER;
            end else begin
                enter_fly_s = 1'b1;
            end
        end else begin
            duck_num_d = duck_num_d;
        end

        // Every entry into FLY reloads the shells and restarts the flight clock.
        if (enter_fly_s) begin
            state_d     = S_FLY;
            shots_d     = SHOTS_LIM;
            fly_timer_d = 9'd0;
            new_duck_d  = 1'b1;
        end else begin
            new_duck_d = 1'b0;
        end
    end

    // Sequencer state and counter flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_TITLE;
            dog_next_q   <= NEXT_INTRO;
            shots_q      <= 2'd0;
            ducks_hit_q  <= 4'd0;
            duck_num_q   <= 4'd0;
            fly_timer_q  <= 9'd0;
            miss_timer_q <= 9'd0;
            new_duck_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dog_next_q   <= dog_next_d;
            shots_q      <= shots_d;
            ducks_hit_q  <= ducks_hit_d;
            duck_num_q   <= duck_num_d;
            fly_timer_q  <= fly_timer_d;
            miss_timer_q <= miss_timer_d;
            new_duck_q   <= new_duck_d;
        end
    end

    assign state      = state_q;
    assign new_duck   = new_duck_q;
    assign shots_left = shots_q;
    assign ducks_hit  = ducks_hit_q;
    assign duck_num   = duck_num_q;

endmodule

// File: doc/game_control.md
# game_control

Top-level game sequencer for the duck-hunt datapath. It drives the 3-bit `state` bus consumed by the dog sprite block and the duck/HUD blocks, and it consumes the dog's `dog_start`/`dog_duck` completion pulses. It also tracks shots, hits, duck count and the fly-away timeout. Every transition of the dog animation (reposition, intro, duck retrieval) is commanded from here.

## Interface
- `DUCKS_PER_GAME`, 10: ducks per game before GAME_OVER.
- `SHOTS_PER_DUCK`, 3: shells loaded per duck.
- `FLY_FRAMES`, 300: frame-edges a duck may fly before escaping.
- `FLYAWAY_FRAMES`, 90: frame-edges spent in MISS.
- `Clk` in 1: 50 MHz clock.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: ~60 Hz frame clock, asynchronous level.
- `start_btn` in 1: start/restart button level.
- `trigger` in 1: gun trigger level.
- `hit` in 1: single-`Clk` pulse from the hit detector (shot landed on duck).
- `duck_landed` in 1: single-cycle pulse, falling duck reached ground.
- `dog_start` in 1: single-cycle pulse, dog intro finished.
- `dog_duck` in 1: single-cycle pulse, dog retrieval finished.
- `state` out 3: game state bus.
- `new_duck` out 1: one-cycle pulse on every entry into FLY.
- `shots_left` out 2: remaining shells.
- `ducks_hit` out 4: ducks hit this game.
- `duck_num` out 4: ducks completed this game.

## Operation
- State encodings:
  - TITLE=000
  - MISS=001
  - DOG_RESET=010
  - FLY=011
  - FALL=100
  - DOG_DUCK=101
  - DOG_INTRO=110
  - GAME_OVER=111
- Frame edge detection:
  - `frame_clk` is registered once into `fc_d`.
  - `fe` is the registered value of `frame_clk & ~fc_d`, so it is a one-cycle pulse per frame.
- Button edges:
  - `start_btn` and `trigger` are each registered; the rising edge is `x & ~x_d`.
  - A held button counts once.
- TITLE: start edge → DOG_RESET with `dog_next`=INTRO.
- DOG_RESET:
  - Held exactly 1 cycle.
  - Next state is DOG_INTRO if `dog_next`=INTRO, otherwise DOG_DUCK.
- DOG_INTRO: `dog_start` → FLY.
- Entry into FLY (from any source):
  - `shots_left`←`SHOTS_PER_DUCK`, `fly_timer`←0.
  - `new_duck`=1 for that cycle.
- FLY, evaluated each cycle with priority hit > out-of-shots > timeout:
  - Trigger edge with `shots_left`>0: `shots_left` decrements. Trigger edge with `shots_left`=0 is ignored.
  - `hit`: `ducks_hit`+1 (saturating at 15) → FALL.
  - Trigger edge that takes `shots_left` 1→0 without `hit` in the same cycle → MISS.
  - `fe` increments `fly_timer`. Reaching `FLY_FRAMES` → MISS.
- FALL: `duck_landed` → DOG_RESET with `dog_next`=DUCK.
- DOG_DUCK: `dog_duck` → duck-complete.
- MISS: `miss_timer` counts `fe`. Reaching `FLYAWAY_FRAMES` → duck-complete.
- Duck-complete (from DOG_DUCK or MISS):
  - `duck_num`+1.
  - If the new value equals `DUCKS_PER_GAME` → GAME_OVER, otherwise → FLY.
- GAME_OVER:
  - Counters freeze.
  - Start edge → clear `ducks_hit`, `duck_num`, timers → DOG_RESET with `dog_next`=INTRO.
- Input qualification:
  - `dog_start` is ignored outside DOG_INTRO. `dog_duck` is ignored outside DOG_DUCK.
  - `hit` is ignored outside FLY. `duck_landed` is ignored outside FALL.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=000 (TITLE)
  - `shots_left`=0, `ducks_hit`=0, `duck_num`=0, `new_duck`=0
  - `dog_next`=INTRO, timers 0, edge registers 0
- Latency:
  - An input event sampled on edge N shows its new `state` after edge N.
  - Button events carry 1 additional cycle for edge detection.
- DOG_RESET is on `state` for exactly 1 `Clk`. Every entry to DOG_INTRO/DOG_DUCK passes through it.
- `fly_timer` and `miss_timer` are 9-bit and count only on `fe`, never on `Clk`.
- Simultaneous `hit` and timeout in the same cycle: hit wins.
- Simultaneous last shot and `hit`: `shots_left`→0 and the next state is FALL.
- Reset mid-game: everything returns to TITLE on the next edge, regardless of state.

## Test plan
- Reset, then press start → `state` 000→010 for 1 cycle →110; pulse `dog_start` → 011 and `new_duck`=1, `shots_left`=3.
- In FLY, three separate trigger presses with no hit → `shots_left` 3→2→1→0, then `state`=001. After 90 frame edges → 011 with `duck_num`=1.
- In FLY, trigger and `hit` in the same cycle → `shots_left`=2, `ducks_hit`=1, `state`=100. Then:
  - `duck_landed` → 010 (1 cycle) → 101.
  - `dog_duck` → 011.
- In FLY with no input, 300 frame edges → 001. A trigger held high across 50 cycles → exactly one decrement.
- Complete 10 ducks → `state`=111 with `duck_num`=10 frozen. Start edge → `ducks_hit`=0, `duck_num`=0, `state` 010→110.
- Assert `Reset` during FALL → `state`=000 and all counters 0 next cycle. `dog_duck` pulsed in TITLE → no change.
